// File: rtl/write_s_pkg.sv
// -----------------------------------------------------------------------------
// write_s_pkg
// Shared definitions for the IDCT write-back stage (write_s).
//   - write_s_state_type : write-back FSM states
//   - plane_sel_type     : target colour plane encoding
//   - default plane word offsets and per-pixel-row SRAM strides
//   - shift_add          : constant multiply built from shifts and adds
// Build option: WRITE_S_CLIP_EN (used by pix_clip / write_s) selects
// saturation instead of truncation when packing pixels.
// -----------------------------------------------------------------------------
package write_s_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LEAD_IN  = 2'd1,
    S_RUN      = 2'd2,
    S_LEAD_OUT = 2'd3
  } write_s_state_type;

  // Codes 2 and 3 both address the V plane.
  typedef enum logic [1:0] {
    PLANE_Y     = 2'd0,
    PLANE_U     = 2'd1,
    PLANE_V     = 2'd2,
    PLANE_V_ALT = 2'd3
  } plane_sel_type;

  localparam logic [17:0] Y_OFFSET_DEF = 18'd0;
  localparam logic [17:0] U_OFFSET_DEF = 18'd38400;
  localparam logic [17:0] V_OFFSET_DEF = 18'd57600;

  // SRAM words per pixel row (two pixels per word).
  localparam logic [17:0] ROW_STRIDE_Y  = 18'd160;
  localparam logic [17:0] ROW_STRIDE_UV = 18'd80;

  // An 8x8 block spans 8 pixel rows.
  localparam int unsigned BLOCK_ROWS_LOG2 = 3;

  // 32 words per block, indices 0..31.
  localparam logic [4:0] LAST_WORD = 5'd31;

  localparam logic [7:0] PIX_MAX = 8'hFF;

  // Multiply by a constant as a sum of shifted copies; with k tied to a
  // constant only the set bits of k leave adders behind.
  function automatic logic [17:0] shift_add(input logic [17:0] x,
                                            input logic [17:0] k);
    logic [17:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < 18; i++) begin
      if (k[i]) acc = acc + (x << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/write_s_pix_clip.sv
// -----------------------------------------------------------------------------
// pix_clip
// Converts one signed 32-bit IDCT result to an 8-bit pixel.
//   pix_in  : signed IDCT coefficient result
//   pix_out : 8-bit pixel
// Build option WRITE_S_CLIP_EN:
//   defined   -> saturate (negative -> 0, above 255 -> 255)
//   undefined -> keep the low 8 bits
// -----------------------------------------------------------------------------
module pix_clip
  import write_s_pkg::*;
(
  input  logic signed [31:0] pix_in,
  output logic        [7:0]  pix_out
);

`ifdef WRITE_S_CLIP_EN
  always_comb begin
    pix_out = pix_in[7:0];
    if (pix_in[31]) begin
      pix_out = '0;
    end else if (|pix_in[30:8]) begin
      pix_out = PIX_MAX;
    end
  end
`else
  always_comb begin
    pix_out = 8'(pix_in);
  end
`endif

endmodule

// File: rtl/write_s.sv
// -----------------------------------------------------------------------------
// write_s
// Writes one 8x8 IDCT output block from a dual-port RAM back to SRAM as 32
// packed pixel-pair words (even pixel in the high byte).
//   clock            : rising-edge clock
//   resetn           : synchronous reset, active HIGH despite the name
//   write_start      : start request, honoured only while idle
//   col_block        : block column, row_block : block row
//   sel              : target plane (0=Y, 1=U, 2/3=V)
//   dp_address_a/b   : DPRAM pixel addresses (even / odd pixel of a word)
//   dp_read_data_a/b : DPRAM read data, valid one cycle after the address
//   SRAM_address     : SRAM word address
//   SRAM_write_data  : packed pixel pair
//   SRAM_we_n        : active-low SRAM write strobe
//   busy             : block in progress
//   write_finish     : one-cycle pulse after the last word
// Build option WRITE_S_CLIP_EN: saturating pixel conversion (see pix_clip).
//
// Timing from the accepting edge E0: addresses for word k leave at Ek, the
// RAM answers in cycle k+1, and the word is registered onto the SRAM bus at
// E(k+2). So words occupy cycles 2..33 and write_finish appears in cycle 34.
// -----------------------------------------------------------------------------
module write_s
  import write_s_pkg::*;
#(
  parameter logic [17:0] Y_OFFSET = Y_OFFSET_DEF,
  parameter logic [17:0] U_OFFSET = U_OFFSET_DEF,
  parameter logic [17:0] V_OFFSET = V_OFFSET_DEF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        write_start,
  input  logic [5:0]  col_block,
  input  logic [5:0]  row_block,
  input  logic [1:0]  sel,
  output logic [6:0]  dp_address_a,
  output logic [6:0]  dp_address_b,
  input  logic [31:0] dp_read_data_a,
  input  logic [31:0] dp_read_data_b,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        busy,
  output logic        write_finish
);

  localparam logic [6:0] DP_LAST_A = {1'b0, LAST_WORD, 1'b0};

  write_s_state_type state, state_n;

  logic [5:0]    col_q;
  logic [5:0]    row_q;
  plane_sel_type sel_q;
  logic [4:0]    wr_k;       // index of the word registered at the next edge
  logic          accept;
  logic [7:0]    pix_a;
  logic [7:0]    pix_b;
  logic [17:0]   plane_base;
  logic [17:0]   row_stride;
  logic [17:0]   word_addr;

  // ---------------------------------------------------------------------------
  // Pixel conversion
  // ---------------------------------------------------------------------------
  pix_clip u_clip_a (
    .pix_in  (dp_read_data_a),
    .pix_out (pix_a)
  );

`ifdef WRITE_S_CLIP_EN
  pix_clip u_clip_b (
    .pix_in  (dp_read_data_b),
    .pix_out (pix_b)
  );
`else
  always_comb begin
    pix_b = 8'(dp_read_data_b);
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    accept = (state == S_IDLE) && write_start;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (write_start) state_n = S_LEAD_IN;
      S_LEAD_IN:  state_n = S_RUN;
      S_RUN:      if (wr_k == LAST_WORD) state_n = S_LEAD_OUT;
      S_LEAD_OUT: state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM word address: base + row_block*8*stride + (k>>2)*stride
  //                    + col_block*4 + (k&3)
  // ---------------------------------------------------------------------------
  always_comb begin
    plane_base = V_OFFSET;
    row_stride = ROW_STRIDE_UV;
    case (sel_q)
      PLANE_Y: begin
        plane_base = Y_OFFSET;
        row_stride = ROW_STRIDE_Y;
      end
      PLANE_U: begin
        plane_base = U_OFFSET;
        row_stride = ROW_STRIDE_UV;
      end
      default: begin
        plane_base = V_OFFSET;
        row_stride = ROW_STRIDE_UV;
      end
    endcase

    word_addr = plane_base
              + shift_add({12'd0, row_q}, row_stride << BLOCK_ROWS_LOG2)
              + shift_add({15'd0, wr_k[4:2]}, row_stride)
              + {10'd0, col_q, 2'b00}
              + {16'd0, wr_k[1:0]};
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (resetn) begin
      col_q           <= '0;
      row_q           <= '0;
      sel_q           <= PLANE_Y;
      wr_k            <= '0;
      dp_address_a    <= '0;
      dp_address_b    <= '0;
      SRAM_address    <= Y_OFFSET;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
      busy            <= 1'b0;
      write_finish    <= 1'b0;
    end else begin
      busy         <= (state_n != S_IDLE);
      write_finish <= (state == S_LEAD_OUT);
      SRAM_we_n    <= (state != S_RUN);

      if (accept) begin
        col_q        <= col_block;
        row_q        <= row_block;
        sel_q        <= plane_sel_type'(sel);
        wr_k         <= '0;
        dp_address_a <= 7'd0;
        dp_address_b <= 7'd1;
      end

      // Address stream runs one word ahead of the write stream and parks on
      // the last pair once it has been issued.
      if ((state == S_LEAD_IN || state == S_RUN) && (dp_address_a != DP_LAST_A)) begin
        dp_address_a <= dp_address_a + 7'd2;
        dp_address_b <= dp_address_b + 7'd2;
      end

      if (state == S_RUN) begin
        SRAM_address    <= word_addr;
        SRAM_write_data <= {pix_a, pix_b};
        wr_k            <= wr_k + 5'd1;
      end
    end
  end

endmodule
